lsu_rd_router: RTL and testbench

LSU_RD_ROUTER -- requirements
Module: lsu_rd_router

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_load_align.sv | 44 ++++
 rtl/lsu_rd_router.sv | 168 ++++++++++++++++
 tb/tb_lsu_rd_router.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared region map, load-size encodings and router defaults
//               for the LSU read router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam int c_num_map = 3;
    localparam int c_map_aw  = 16;

    // Region k matches when (addr & c_mask[k]) == c_base[k]; element 0 is the highest priority.
    localparam logic [c_num_map-1:0][c_map_aw-1:0] c_base = {16'h7800, 16'h7000, 16'h2000};
    localparam logic [c_num_map-1:0][c_map_aw-1:0] c_mask = {16'hFFE0, 16'hFFC0, 16'hE000};

    localparam int c_timeout_cyc = 15;

    typedef enum logic [2:0] {
        LS_LB  = 3'b000,
        LS_LH  = 3'b001,
        LS_LW  = 3'b010,
        LS_LBU = 3'b100,
        LS_LHU = 3'b101
    } ld_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rtr_state_e;

    // Accepts only defined funct3 codes with natural alignment.
    function automatic logic ld_size_ok(input logic [2:0] size, input logic [1:0] lsb);
        logic ok;
        ok = 1'b0;
        case (size)
            LS_LB, LS_LBU: ok = 1'b1;
            LS_LH, LS_LHU: ok = ~lsb[0];
            LS_LW:         ok = (lsb == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational byte/half extraction and sign/zero extension
//               of a read word according to the RISC-V load size.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_addr_lo,
    input  logic [2:0]        i_size,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_byte_sh;
    logic [DATA_W-1:0] w_half_sh;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign w_byte_sh = i_word >> {i_addr_lo, 3'b000};
    assign w_half_sh = i_word >> {i_addr_lo[1], 4'b0000};
    assign w_byte    = w_byte_sh[7:0];
    assign w_half    = w_half_sh[15:0];

    always_comb begin
        o_data = '0;
        case (i_size)
            LS_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LS_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
            LS_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            LS_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
            LS_LW:   o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_rd_router.sv
// ============================================================================
// Module      : lsu_rd_router
// Description : Routes single LSU loads to one of several mapped read regions,
//               aligns the returned data and reports decode/timeout errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_rd_router
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int NUM_REG     = 3,
    parameter int TIMEOUT_CYC = c_timeout_cyc
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [ADDR_W-1:0]         i_req_addr,
    input  logic [2:0]                i_req_size,
    output logic [NUM_REG-1:0]        o_rd_en,
    output logic [ADDR_W-1:0]         o_rd_addr,
    input  logic [NUM_REG*DATA_W-1:0] i_rd_data,
    input  logic [NUM_REG-1:0]        i_rd_valid,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_rsp_err
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);

    rtr_state_e                r_state;
    rtr_state_e                w_state_nxt;
    logic [NUM_REG-1:0]        w_hit;
    logic [NUM_REG-1:0]        w_sel_oh;
    logic                      w_legal;
    logic [NUM_REG-1:0]        r_sel;
    logic [2:0]                r_size;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [ADDR_W-1:0]         r_rd_addr;
    logic                      r_rsp_valid;
    logic [DATA_W-1:0]         r_rsp_data;
    logic                      r_rsp_err;
    logic                      w_sel_valid;
    logic                      w_timeout;
    logic [NUM_REG:0][DATA_W-1:0] w_or;
    logic [DATA_W-1:0]         w_aligned;

    genvar k;
    generate
        for (k = 0; k < NUM_REG; k++) begin : g_region
            if (k < c_num_map) begin : g_map
                assign w_hit[k] = ((i_req_addr & ADDR_W'(c_mask[k])) == ADDR_W'(c_base[k]));
            end else begin : g_unmapped
                assign w_hit[k] = 1'b0;
            end
            // One-hot select makes the read-data mux a plain AND-OR tree.
            assign w_or[k+1] = w_or[k] | (i_rd_data[k*DATA_W +: DATA_W] & {DATA_W{r_sel[k]}});
        end
    endgenerate

    assign w_or[0]  = '0;
    // Isolate the lowest set bit so the lowest-numbered region wins on overlap.
    assign w_sel_oh = w_hit & (~w_hit + NUM_REG'(1));
    assign w_legal  = (|w_hit) && ld_size_ok(i_req_size, i_req_addr[1:0]);

    assign w_sel_valid = |(i_rd_valid & r_sel);
    assign w_timeout   = (r_cnt == c_cnt_w'(TIMEOUT_CYC - 1));

    lsu_load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_word    (w_or[NUM_REG]),
        .i_addr_lo (r_rd_addr[1:0]),
        .i_size    (r_size),
        .o_data    (w_aligned)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_state_nxt = w_legal ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (w_sel_valid || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sel       <= '0;
            r_size      <= '0;
            r_cnt       <= '0;
            r_rd_addr   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_rd_addr <= i_req_addr;
                        r_size    <= i_req_size;
                        r_sel     <= w_legal ? w_sel_oh : '0;
                        r_cnt     <= '0;
                        if (!w_legal) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    // Valid data takes precedence over a timeout in the same cycle.
                    if (w_sel_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= w_aligned;
                    end else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rd_en     = (r_state == ST_WAIT) ? r_sel : '0;
    assign o_rd_addr   = r_rd_addr;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_rd_router.sv
// ============================================================================
// Module      : tb_lsu_rd_router
// Description : Self-checking bench for lsu_rd_router: directed loads plus
//               randomized traffic against an address-range reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_rd_router;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int NUM_REG     = 3;
    localparam int TIMEOUT_CYC = 15;

    logic                      i_clk = 1'b0;
    logic                      i_reset = 1'b1;
    logic                      i_req_valid = 1'b0;
    logic                      o_req_ready;
    logic [ADDR_W-1:0]         i_req_addr = '0;
    logic [2:0]                i_req_size = '0;
    logic [NUM_REG-1:0]        o_rd_en;
    logic [ADDR_W-1:0]         o_rd_addr;
    logic [NUM_REG*DATA_W-1:0] i_rd_data = '0;
    logic [NUM_REG-1:0]        i_rd_valid = '0;
    logic                      o_rsp_valid;
    logic                      i_rsp_ready = 1'b0;
    logic [DATA_W-1:0]         o_rsp_data;
    logic                      o_rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    lsu_rd_router #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_REG     (NUM_REG),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_req_size  (i_req_size),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .i_rd_valid  (i_rd_valid),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Region from inclusive address ranges of the memory map.
    function automatic int ref_region(input logic [15:0] a);
        if (a >= 16'h2000 && a <= 16'h3FFF) return 0;
        if (a >= 16'h7000 && a <= 16'h703F) return 1;
        if (a >= 16'h7800 && a <= 16'h781F) return 2;
        return -1;
    endfunction

    function automatic logic ref_legal(input logic [15:0] a, input logic [2:0] sz);
        int al;
        al = int'(a) % 4;
        if (ref_region(a) < 0) return 1'b0;
        case (sz)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (al % 2) == 0;
            3'd2:       return al == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] w, input logic [15:0] a, input logic [2:0] sz);
        int unsigned lane_b;
        int unsigned lane_h;
        int unsigned b;
        int unsigned h;
        lane_b = int'(a) % 4;
        lane_h = (int'(a) % 4) / 2;
        b = (w / (32'd1 << (8 * lane_b))) % 256;
        h = (w / (32'd1 << (16 * lane_h))) % 65536;
        case (sz)
            3'd0:    return (b >= 128) ? 32'(b + 32'hFFFFFF00) : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF0000) : 32'(h);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    // Issue one load, play the memory side, then hold the response for hold_n cycles.
    task automatic run_txn(input logic [15:0] a, input logic [2:0] sz, input logic [31:0] word,
                           input int wait_n, input int hold_n);
        int          reg_k;
        logic        legal;
        int          n;
        int          exp_n;
        logic [2:0]  exp_en;
        logic [31:0] exp_d;
        logic        exp_e;
        logic [2:0]  noise;
        reg_k  = ref_region(a);
        legal  = ref_legal(a, sz);
        exp_en = legal ? 3'(1 << reg_k) : 3'b000;
        if (!legal) begin
            exp_n = 0;  exp_d = 32'h0; exp_e = 1'b1;
        end else if (wait_n < TIMEOUT_CYC) begin
            exp_n = wait_n + 1; exp_d = ref_data(word, a, sz); exp_e = 1'b0;
        end else begin
            exp_n = TIMEOUT_CYC; exp_d = 32'h0; exp_e = 1'b1;
        end

        check("req_ready_idle", {63'd0, o_req_ready}, 64'd1);
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_size  = sz;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_req_addr  = 16'($urandom);
        i_req_size  = 3'($urandom);

        n = 0;
        while (!o_rsp_valid && n < 40) begin
            check("rd_en_wait", {61'd0, o_rd_en}, {61'd0, exp_en});
            check("rd_addr", {48'd0, o_rd_addr}, {48'd0, a});
            noise      = 3'($urandom);
            i_rd_valid = noise & ~exp_en;
            i_rd_data  = {$urandom, $urandom, $urandom};
            if (n == wait_n && legal) begin
                i_rd_valid = i_rd_valid | exp_en;
                i_rd_data[reg_k*32 +: 32] = word;
            end
            @(negedge i_clk);
            n++;
        end
        i_rd_valid = '0;

        check("latency", 64'(n), 64'(exp_n));
        check("rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
        check("rsp_data", {32'd0, o_rsp_data}, {32'd0, exp_d});
        check("rsp_err", {63'd0, o_rsp_err}, {63'd0, exp_e});
        check("rd_en_resp", {61'd0, o_rd_en}, 64'd0);

        for (int h = 0; h < hold_n; h++) begin
            @(negedge i_clk);
            check("hold_valid", {63'd0, o_rsp_valid}, 64'd1);
            check("hold_data", {32'd0, o_rsp_data}, {32'd0, exp_d});
            check("hold_err", {63'd0, o_rsp_err}, {63'd0, exp_e});
            check("hold_req_ready", {63'd0, o_req_ready}, 64'd0);
        end

        // A legal request presented during the handshake cycle must be ignored.
        i_rsp_ready = 1'b1;
        i_req_valid = 1'b1;
        i_req_addr  = 16'h2000;
        i_req_size  = 3'd2;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b0;
        check("post_hs_valid", {63'd0, o_rsp_valid}, 64'd0);
        check("post_hs_ready", {63'd0, o_req_ready}, 64'd1);
        check("post_hs_rd_en", {61'd0, o_rd_en}, 64'd0);
    endtask

    initial begin
        logic [15:0] ra;
        int          wn;

        repeat (3) @(negedge i_clk);
        check("rst_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
        check("rst_rsp_data", {32'd0, o_rsp_data}, 64'd0);
        check("rst_rsp_err", {63'd0, o_rsp_err}, 64'd0);
        check("rst_rd_en", {61'd0, o_rd_en}, 64'd0);
        check("rst_rd_addr", {48'd0, o_rd_addr}, 64'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("rst_req_ready", {63'd0, o_req_ready}, 64'd1);

        run_txn(16'h2004, 3'd2, 32'hDEADBEEF, 0, 0);
        run_txn(16'h7003, 3'd0, 32'h80FF1234, 0, 0);
        run_txn(16'h7003, 3'd4, 32'h80FF1234, 2, 0);
        run_txn(16'h7802, 3'd5, 32'hABCD0000, 1, 0);
        run_txn(16'h5000, 3'd2, 32'h12345678, 0, 0);
        run_txn(16'h2001, 3'd1, 32'h12345678, 0, 0);
        run_txn(16'h2000, 3'd3, 32'h12345678, 0, 0);
        run_txn(16'h7000, 3'd2, 32'hCAFEF00D, 100, 0);
        run_txn(16'h7000, 3'd2, 32'hCAFEF00D, TIMEOUT_CYC - 1, 0);
        run_txn(16'h781E, 3'd1, 32'h8001_7FFF, 3, 5);

        // Reset asserted while waiting must abort the request silently.
        i_req_valid = 1'b1;
        i_req_addr  = 16'h7000;
        i_req_size  = 3'd2;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("pre_rst_rd_en", {61'd0, o_rd_en}, 64'd2);
        #2 i_reset = 1'b1;
        #1;
        check("mid_rst_rd_en", {61'd0, o_rd_en}, 64'd0);
        check("mid_rst_valid", {63'd0, o_rsp_valid}, 64'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            i_rd_valid = 3'b111;
            @(negedge i_clk);
            check("after_rst_valid", {63'd0, o_rsp_valid}, 64'd0);
            check("after_rst_ready", {63'd0, o_req_ready}, 64'd1);
        end
        i_rd_valid = '0;

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 3))
                0:       ra = 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
                1:       ra = 16'h7000 + 16'($urandom_range(0, 63));
                2:       ra = 16'h7800 + 16'($urandom_range(0, 31));
                default: ra = 16'($urandom);
            endcase
            wn = ($urandom_range(0, 4) == 0) ? $urandom_range(12, 17) : $urandom_range(0, 3);
            run_txn(ra, 3'($urandom_range(0, 7)), $urandom, wn, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
